// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with jump, relative branch and call/return through an
// internal return-address stack carrying sticky overflow/underflow flags.
module pc_stack_unit #(
   parameter int unsigned         ADDR_W      = 4,
   parameter int unsigned         STACK_DEPTH = 4,
   parameter logic [ADDR_W-1:0]   RESET_ADDR  = '0,
   localparam int unsigned        SP_W        = $clog2(STACK_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              halt,
   input  logic              ir_load_en,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   input  logic              branch_en,
   input  logic [ADDR_W-1:0] branch_off,
   input  logic              call_en,
   input  logic              ret_en,
   input  logic              err_clr,
   output logic [ADDR_W-1:0] pc_out,
   output logic [SP_W-1:0]   sp_count,
   output logic              stack_full,
   output logic              stack_ovf,
   output logic              stack_unf
);

   // Storage is rounded up to a power of two so the stack pointer slices cleanly.
   localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [ADDR_W-1:0] stack_mem [2**IDX_W];

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [SP_W-1:0]   sp_q, sp_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic              adv;
   logic              full;
   logic              empty;
   logic              push_en;
   logic [ADDR_W-1:0] pc_inc;
   logic [SP_W-1:0]   sp_dec;
   logic [IDX_W-1:0]  push_idx;
   logic [IDX_W-1:0]  pop_idx;

   assign adv      = ir_load_en & ~halt;
   assign full     = (sp_q == SP_W'(STACK_DEPTH));
   assign empty    = (sp_q == '0);
   assign pc_inc   = pc_q + ADDR_W'(1);
   assign sp_dec   = sp_q - SP_W'(1);
   assign push_idx = sp_q[IDX_W-1:0];
   assign pop_idx  = sp_dec[IDX_W-1:0];

   always_comb begin
      pc_d    = pc_q;
      sp_d    = sp_q;
      ovf_d   = ovf_q & ~err_clr;
      unf_d   = unf_q & ~err_clr;
      push_en = 1'b0;
      if (jump_en) begin
         pc_d = jump_addr;
      end else if (adv && call_en) begin
         if (!full) begin
            push_en = 1'b1;
            sp_d    = sp_q + SP_W'(1);
            pc_d    = jump_addr;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (adv && ret_en) begin
         if (!empty) begin
            pc_d = stack_mem[pop_idx];
            sp_d = sp_dec;
         end else begin
            unf_d = 1'b1;
         end
      end else if (adv && branch_en) begin
         pc_d = pc_q + branch_off;
      end else if (adv) begin
         pc_d = pc_inc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q  <= RESET_ADDR;
         sp_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Return-address storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (push_en) begin
         stack_mem[push_idx] <= pc_inc;
      end
   end

   assign pc_out     = pc_q;
   assign sp_count   = sp_q;
   assign stack_full = full;
   assign stack_ovf  = ovf_q;
   assign stack_unf  = unf_q;

endmodule
